// File: rtl/fetch_stage_pkg.sv
// Shared defaults and next-PC selection helper for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned PC_W_DEFAULT      = 32;
  localparam int unsigned INSTR_W_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_JUMP   = 2'd2
  } pc_sel_e;

  // Jump outranks a taken branch when decode raises both.
  function automatic pc_sel_e pc_select(input logic jump, input logic branch);
    if (jump)        return PC_SEL_JUMP;
    else if (branch) return PC_SEL_BRANCH;
    else             return PC_SEL_SEQ;
  endfunction

endpackage

// File: rtl/fetch_stage_adder.sv
// Generic unsigned adder; result truncated to outw bits, carry-out discarded.
module fetch_stage_adder #(
  parameter int inw1 = 32,
  parameter int inw2 = 1,
  parameter int outw = inw1
) (
  input  logic [inw1-1:0] a_i,
  input  logic [inw2-1:0] b_i,
  output logic [outw-1:0] sum_o
);

  assign sum_o = outw'(a_i) + outw'(b_i);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEFAULT,
  parameter int                 INSTR_W   = INSTR_W_DEFAULT,
  parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(RESET_PC_DEFAULT),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PCSrcD,
  input  logic               JumpD,
  input  logic [PC_W-1:0]    PCBranchD,
  input  logic [PC_W-1:0]    PCJumpD,
  input  logic [INSTR_W-1:0] InstrF,
  output logic [PC_W-1:0]    PCF,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCp1D,
  output logic               ValidD
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pcp1_f;
  logic [PC_W-1:0]    pc_next;
  pc_sel_e            pc_sel;

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pcp1_q, pcp1_d;
  logic               valid_q, valid_d;

  fetch_stage_adder #(
    .inw1 (PC_W),
    .inw2 (1),
    .outw (PC_W)
  ) u_pc_inc (
    .a_i   (pc_q),
    .b_i   (1'b1),
    .sum_o (pcp1_f)
  );

  always_comb begin
    pc_sel  = pc_select(JumpD, PCSrcD);
    pc_next = pcp1_f;
    case (pc_sel)
      PC_SEL_JUMP:   pc_next = PCJumpD;
      PC_SEL_BRANCH: pc_next = PCBranchD;
      default:       pc_next = pcp1_f;
    endcase
  end

  // A stalled PC ignores any redirect presented in the same cycle.
  always_comb begin
    pc_d = pc_next;
    if (StallF) pc_d = pc_q;
  end

  always_comb begin
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      pcp1_d  = '0;
      valid_d = 1'b0;
    end else if (!StallD) begin
      instr_d = InstrF;
      pcp1_d  = pcp1_f;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
    end
  end

  assign PCF    = pc_q;
  assign InstrD = instr_q;
  assign PCp1D  = pcp1_q;
  assign ValidD = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, a reset-mid-stall sequence, and randomized run against a model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, FlushD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCJumpD, InstrF;
  logic [31:0] PCF, InstrD, PCp1D;
  logic        ValidD;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h0000_1000 + a;
  endfunction

  assign InstrF = imem(PCF);

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcD    (PCSrcD),
    .JumpD     (JumpD),
    .PCBranchD (PCBranchD),
    .PCJumpD   (PCJumpD),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCp1D     (PCp1D),
    .ValidD    (ValidD)
  );

  typedef struct {
    logic        rs, sf, sd, fl, ps, jp;
    logic [31:0] br, jt;
    logic [31:0] e_pc, e_instr, e_pcp1;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pcp1;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic rs, sf, sd, fl, ps, jp, input logic [31:0] br, jt);
    reset = rs; StallF = sf; StallD = sd; FlushD = fl;
    PCSrcD = ps; JumpD = jp; PCBranchD = br; PCJumpD = jt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, instr, pcp1,
                           input logic valid);
    chk({tag, ".PCF"},    PCF,           pc);
    chk({tag, ".InstrD"}, InstrD,        instr);
    chk({tag, ".PCp1D"},  PCp1D,         pcp1);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, valid});
  endtask

  // One clock of the fetch stage as described by its rules, on the model state.
  task automatic model_step(input logic rs, sf, sd, fl, ps, jp, input logic [31:0] br, jt);
    logic [31:0] fetched, seq, target;
    fetched = imem(m_pc);
    seq     = m_pc + 32'd1;
    target  = jp ? jt : (ps ? br : seq);
    if (rs) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pcp1 = 32'd0; m_valid = 1'b0;
    end else begin
      if (!sf) m_pc = target;
      if (fl) begin
        m_instr = 32'd0; m_pcp1 = 32'd0; m_valid = 1'b0;
      end else if (!sd) begin
        m_instr = fetched; m_pcp1 = seq; m_valid = 1'b1;
      end
    end
  endtask

  function automatic vec_t mk(input logic rs, sf, sd, fl, ps, jp, input logic [31:0] br, jt,
                              input logic [31:0] e_pc, e_instr, e_pcp1, input logic e_valid);
    vec_t v;
    v.rs = rs; v.sf = sf; v.sd = sd; v.fl = fl; v.ps = ps; v.jp = jp;
    v.br = br; v.jt = jt;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pcp1 = e_pcp1; v.e_valid = e_valid;
    return v;
  endfunction

  initial begin
    //               rs sf sd fl ps jp  br          jt             pc            instr         pcp1   valid
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h0,        32'h0,        32'h0,  0)); // reset
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h1,        32'h1000,     32'h1,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h2,        32'h1001,     32'h2,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h3,        32'h1002,     32'h3,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h4,        32'h1003,     32'h4,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h5,        32'h1004,     32'h5,  1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 32'h40,     32'h0,         32'h40,       32'h0,        32'h0,  0)); // branch+flush
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h41,       32'h1040,     32'h41, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h40,     32'h80,        32'h80,       32'h1041,     32'h42, 1)); // jump beats branch
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,      32'h7,         32'h7,        32'h1080,     32'h81, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 32'h40,     32'h0,         32'h7,        32'h1080,     32'h81, 1)); // stall beats branch
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 32'h40,     32'h0,         32'h7,        32'h1080,     32'h81, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h8,        32'h1007,     32'h8,  1)); // resume
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 32'h0,      32'h0,         32'h8,        32'h0,        32'h0,  0)); // flush beats stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h9,        32'h1008,     32'h9,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1009,    32'hA,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h0,        32'h0000_0FFF, 32'h0, 1)); // wrap
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h1,        32'h1000,     32'h1,  1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h40,     32'h80,        32'h0,        32'h0,        32'h0,  0)); // reset wins
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h1,        32'h1000,     32'h1,  1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,      32'h0,         32'h2,        32'h1000,     32'h1,  1)); // StallD only
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,         32'h3,        32'h1002,     32'h3,  1));

    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rs, vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].ps, vecs[i].jp,
            vecs[i].br, vecs[i].jt);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcp1,
                vecs[i].e_valid);
    end

    // Reset arriving while stalled: first fetch afterwards must come from address 0.
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h20);
    step();
    drive(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    chk("stall_hold.PCF", PCF, 32'h20);
    drive(1, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    step();
    check_all("rst_in_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step();
    check_all("post_rst1", 32'h1, 32'h1000, 32'h1, 1'b1);
    step();
    check_all("post_rst2", 32'h2, 32'h1001, 32'h2, 1'b1);

    // Randomized run against the model, starting from a reset.
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    model_step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step();
    for (int c = 0; c < 400; c++) begin
      logic rs, sf, sd, fl, ps, jp;
      logic [31:0] br, jt;
      sf = ($urandom_range(0, 99) < 20);
      sd = sf;
      if (!sf && $urandom_range(0, 19) == 0) sd = 1'b1;
      fl = ($urandom_range(0, 9) == 0);
      ps = ($urandom_range(0, 5) == 0);
      jp = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 49) == 0);
      br = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      jt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      drive(rs, sf, sd, fl, ps, jp, br, jt);
      model_step(rs, sf, sd, fl, ps, jp, br, jt);
      step();
      check_all($sformatf("rnd%0d", c), m_pc, m_instr, m_pcp1, m_valid);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
